ir_beam_emitter: RTL and testbench
==================================

// Module: ir_beam_emitter
// PURPOSE
//  Drives the IR LED opposite the pong-cup break-beam sensor with carrier-modulated bursts
//  (38 kHz default), so the demodulating receiver sees a clean beam.
//  Emits a burst/gap pattern and a one-cycle sample strobe at each burst end. The sensor
//  logic samples its active-low detect input on that strobe to qualify beam hits.
//  Runs bursts continuously while enabled, or one burst per start pulse.
// PARAMETERS
//  CLK_HZ        100_000_000  system clock frequency
//  CARRIER_HZ    38_000       IR carrier frequency
//  BURST_CYCLES  20           carrier periods per burst (>=1)
//  GAP_CYCLES    20           carrier periods of silence after each burst (>=1)
//  HALF_PERIOD   CLK_HZ/(2*CARRIER_HZ), truncated (1315 default), derived localparam
// PORTS
//  clk            in   1   system clock, rising edge
//  rst            in   1   asynchronous reset, active-high
//  enable         in   1   level: continuous burst/gap operation
//  start          in   1   single-cycle pulse: one burst+gap, only when idle and enable=0
//  tx_ir          out  1   modulated IR LED drive, registered, high = LED on
//  burst_active   out  1   high for every clock of a burst
//  busy           out  1   high whenever state != IDLE
//  sample_strobe  out  1   one-clock pulse on the last clock of each burst
//  burst_count    out  16  completed bursts, wraps 0xFFFF->0x0000
// BEHAVIOUR
//  Reset is asynchronous and active-high on rst. It forces IDLE and clears all
//   counters. All outputs reset to 0, and tx_ir drops low immediately, even mid-burst.
//  States:
//   IDLE: tx_ir=0, burst_active=0.
//   BURST: carrier toggling, burst_active=1.
//   GAP: tx_ir=0.
//  Transitions:
//   IDLE->BURST on the edge sampling enable=1, or start=1 with enable=0.
//   BURST->GAP after 2*BURST_CYCLES half-periods.
//   GAP->BURST at gap end if enable=1, otherwise GAP->IDLE.
//  Latency: tx_ir=1, burst_active=1 and busy=1 are visible in the cycle after the
//   edge that leaves IDLE. The carrier always starts in its high phase.
//  Carrier: half-period counter runs 0..HALF_PERIOD-1. tx_ir toggles on the terminal
//   count, so each half-period is HALF_PERIOD clocks.
//   Burst length = 2*BURST_CYCLES*HALF_PERIOD clocks. Gap = 2*GAP_CYCLES*HALF_PERIOD clocks.
//  On the last burst clock:
//   - sample_strobe=1 for exactly that clock;
//   - burst_count increments by 1 on the same edge;
//   - the following cycle is GAP, with tx_ir=0.
//  Enable drop mid-burst or mid-gap: the current burst and its gap complete in full, then
//   IDLE. Bursts are never truncated.
//  start while busy=1 is ignored (not queued). start with enable=1 is redundant and ignored.
//  enable rising during a single-shot gap: the next burst follows directly at gap end.
//  Counter widths: $clog2 of the maximum count, no overflow possible.
//   burst_count wraps silently.
// STRUCTURE
//  ir_pkg (shared with the sensor/scoring logic):
//   - CLK_HZ, CARRIER_HZ defaults;
//   - state encoding constants IDLE/BURST/GAP.
//  Sub-module: ir_carrier_gen. It holds the HALF_PERIOD prescaler, emits a one-clock
//   half_tick, and is cleared on IDLE->BURST so phase is deterministic.
//  The top level holds the FSM, the half-tick counter for burst/gap length, and burst_count.
// TESTING (sim: CLK_HZ=8, CARRIER_HZ=1 -> HALF_PERIOD=4; BURST_CYCLES=3, GAP_CYCLES=2)
//  1. Reset release with enable=0, start=0 for 50 clocks
//     -> all outputs 0, busy=0, burst_count=0.
//  2. enable=1 held -> tx_ir pattern 1111 0000 repeated 3 times (24 clks), then 16 clks
//     low, then repeat. sample_strobe fires every 40 clks. burst_count reaches 3 after
//     120 clks.
//  3. start pulse with enable=0 -> exactly one 24-clk burst, strobe at clk 24,
//     busy=1 for 40 clks, then IDLE. A second start at clk 10 has no effect.
//  4. enable dropped 5 clks into a burst -> burst finishes all 24 clks and the gap
//     (16 clks), then IDLE. No further tx_ir activity.
//  5. rst asserted mid-burst while tx_ir=1 -> tx_ir=0 and burst_count=0 in the same
//     cycle, state IDLE. After release with enable=1, the burst restarts from high phase.
//  6. Preload burst_count to 0xFFFF (force), run one burst -> burst_count=0x0000,
//     sample_strobe still pulses once.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared IR beam definitions: default clock/carrier rates, FSM state encoding
// and the carrier half-period helper used by the emitter and the sensor logic.
package ir_pkg;

    localparam int unsigned CLK_HZ_DEFAULT     = 32'd100_000_000;
    localparam int unsigned CARRIER_HZ_DEFAULT = 32'd38_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } ir_state_e;

    // Clocks per carrier half-period, truncated.
    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned carrier_hz);
        return clk_hz / (32'd2 * carrier_hz);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier half-period prescaler: emits a one-clock half_tick_o every HALF_PERIOD
// clocks while running; clr_i restarts the phase so every burst begins identically.
module ir_carrier_gen
    import ir_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 32'd1315
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic run_i,
    output logic half_tick_o,
    output logic tick_next_o
);

    localparam int unsigned          CNT_W   = (HALF_PERIOD > 32'd1) ? $clog2(HALF_PERIOD) : 32'd1;
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(HALF_PERIOD - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next prescaler value; held at zero while stopped or being cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !run_i) begin
            cnt_d = CNT_W'(0);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_W'(0);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // tick_next_o lets the FSM register a strobe that lines up with the coming tick.
    assign half_tick_o = run_i && !clr_i && (cnt_q == CNT_MAX);
    assign tick_next_o = (cnt_d == CNT_MAX);

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_W'(0);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_beam_emitter.sv
// IR break-beam emitter: carrier-modulated burst/gap sequencer with a sample
// strobe on the last clock of each burst and a wrapping completed-burst counter.
module ir_beam_emitter
    import ir_pkg::*;
#(
    parameter int unsigned CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int unsigned CARRIER_HZ   = CARRIER_HZ_DEFAULT,
    parameter int unsigned BURST_CYCLES = 32'd20,
    parameter int unsigned GAP_CYCLES   = 32'd20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    output logic        tx_ir,
    output logic        burst_active,
    output logic        busy,
    output logic        sample_strobe,
    output logic [15:0] burst_count
);

    localparam int unsigned HALF_PERIOD = half_period(CLK_HZ, CARRIER_HZ);
    localparam int unsigned MAX_CYCLES  = (BURST_CYCLES > GAP_CYCLES) ? BURST_CYCLES : GAP_CYCLES;
    localparam int unsigned HC_W        = (MAX_CYCLES > 32'd1) ? $clog2(32'd2 * MAX_CYCLES) : 32'd1;
    localparam logic [HC_W-1:0] BURST_LAST = HC_W'(32'd2 * BURST_CYCLES - 32'd1);
    localparam logic [HC_W-1:0] GAP_LAST   = HC_W'(32'd2 * GAP_CYCLES - 32'd1);

    ir_state_e        state_q, state_d;
    logic [HC_W-1:0]  hcnt_q, hcnt_d;
    logic             tx_q, tx_d;
    logic [15:0]      burst_count_q, burst_count_d;
    logic             burst_active_q, busy_q, strobe_q;
    logic             launch_s;
    logic             half_tick_s;
    logic             tick_next_s;

    ir_carrier_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_carrier (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (launch_s),
        .run_i       (state_q != IDLE),
        .half_tick_o (half_tick_s),
        .tick_next_o (tick_next_s)
    );

    // Burst/gap sequencing: lengths are counted in carrier half-periods.
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        tx_d          = tx_q;
        burst_count_d = burst_count_q;
        launch_s      = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b0;
                hcnt_d = HC_W'(0);
                if (enable || start) begin
                    state_d  = BURST;
                    tx_d     = 1'b1;
                    launch_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (!half_tick_s) begin
                    state_d = BURST;
                end else if (hcnt_q == BURST_LAST) begin
                    state_d       = GAP;
                    hcnt_d        = HC_W'(0);
                    tx_d          = 1'b0;
                    burst_count_d = burst_count_q + 16'd1;
                end else begin
                    hcnt_d = hcnt_q + HC_W'(1);
                    tx_d   = ~tx_q;
                end
            end
            GAP: begin
                tx_d = 1'b0;
                if (!half_tick_s) begin
                    state_d = GAP;
                end else if (hcnt_q == GAP_LAST) begin
                    hcnt_d = HC_W'(0);
                    if (enable) begin
                        state_d = BURST;
                        tx_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hcnt_d = hcnt_q + HC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = HC_W'(0);
                tx_d    = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; strobe is registered one clock early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            hcnt_q         <= HC_W'(0);
            tx_q           <= 1'b0;
            burst_count_q  <= 16'd0;
            burst_active_q <= 1'b0;
            busy_q         <= 1'b0;
            strobe_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            hcnt_q         <= hcnt_d;
            tx_q           <= tx_d;
            burst_count_q  <= burst_count_d;
            burst_active_q <= (state_d == BURST);
            busy_q         <= (state_d != IDLE);
            strobe_q       <= (state_d == BURST) && tick_next_s && (hcnt_d == BURST_LAST);
        end
    end

    assign tx_ir         = tx_q;
    assign burst_active  = burst_active_q;
    assign busy          = busy_q;
    assign sample_strobe = strobe_q;
    assign burst_count   = burst_count_q;

endmodule

// File: tb/tb_ir_beam_emitter.sv
// Bench for ir_beam_emitter with HALF_PERIOD=4, 3-cycle bursts and 2-cycle gaps:
// per-cycle scoreboard against a position-in-period model, plus corner sequences.
module tb_ir_beam_emitter;

    localparam int HP = 4;
    localparam int BL = 2 * 3 * HP;       // 24 burst clocks
    localparam int TL = BL + 2 * 2 * HP;  // 40 clocks per burst+gap

    logic        clk;
    logic        rst;
    logic        enable;
    logic        start;
    logic        tx_ir;
    logic        burst_active;
    logic        busy;
    logic        sample_strobe;
    logic [15:0] burst_count;

    ir_beam_emitter #(
        .CLK_HZ       (8),
        .CARRIER_HZ   (1),
        .BURST_CYCLES (3),
        .GAP_CYCLES   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .start         (start),
        .tx_ir         (tx_ir),
        .burst_active  (burst_active),
        .busy          (busy),
        .sample_strobe (sample_strobe),
        .burst_count   (burst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cycles;
        logic        en;
        logic        st;
        logic        exp_busy;
        logic [15:0] exp_count;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_strobe;
    int          n_busy;
    int          n_tx;
    int          cyc = 0;
    logic        m_busy;
    int          m_pos;
    logic [15:0] m_count;
    logic [19:0] sb_q[$];
    vec_t        vecs[4];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_pos   = 0;
        m_count = 16'd0;
    endtask

    task automatic model_edge(input logic en_v, input logic st_v);
        if (!m_busy) begin
            if (en_v || st_v) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end else begin
            if (m_pos == BL - 1) m_count = m_count + 16'd1;
            if (m_pos == TL - 1) begin
                if (en_v) m_pos = 0;
                else m_busy = 1'b0;
            end else begin
                m_pos++;
            end
        end
    endtask

    function automatic logic [19:0] model_out();
        logic ba, tx, stb;
        ba  = m_busy && (m_pos < BL);
        tx  = ba && (((m_pos / HP) % 2) == 0);
        stb = m_busy && (m_pos == BL - 1);
        return {tx, ba, m_busy, stb, m_count};
    endfunction

    // One clock: drive, push expectation at the edge, compare on the falling edge.
    task automatic step(input logic en_v, input logic st_v);
        logic [19:0] exp;
        enable = en_v;
        start  = st_v;
        @(posedge clk);
        model_edge(en_v, st_v);
        sb_q.push_back(model_out());
        @(negedge clk);
        cyc++;
        exp = sb_q.pop_front();
        check("cycle_outputs", {12'd0, tx_ir, burst_active, busy, sample_strobe, burst_count},
              {12'd0, exp});
        if (sample_strobe) n_strobe++;
        if (busy) n_busy++;
        if (tx_ir) n_tx++;
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        enable = 1'b0;
        start  = 1'b0;
        model_reset();

        vecs[0] = '{"idle50",  50, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{"cont120", 120, 1'b1, 1'b0, 1'b1, 16'd3};
        vecs[2] = '{"drain40", 40, 1'b0, 1'b0, 1'b0, 16'd3};
        vecs[3] = '{"shot45",  45, 1'b0, 1'b1, 1'b0, 16'd4};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state", {27'd0, tx_ir, burst_active, busy, sample_strobe} | {16'd0, burst_count},
              32'd0);

        for (int v = 0; v < 4; v++) begin
            n_strobe = 0;
            for (int c = 0; c < vecs[v].cycles; c++) step(vecs[v].en, vecs[v].st && (c == 0));
            check({vecs[v].name, "_busy"}, {31'd0, busy}, {31'd0, vecs[v].exp_busy});
            check({vecs[v].name, "_count"}, {16'd0, burst_count}, {16'd0, vecs[v].exp_count});
        end

        // Single shot with a second start at clk 10 that must be ignored.
        n_strobe = 0; n_busy = 0;
        for (int c = 0; c < 50; c++) step(1'b0, (c == 0) || (c == 9));
        check("shot_busy_clks", n_busy, TL);
        check("shot_strobes", n_strobe, 1);
        check("shot_count", {16'd0, burst_count}, 32'd5);

        // Enable dropped 5 clocks into a burst: burst and gap complete, then silence.
        n_strobe = 0; n_busy = 0;
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 35; c++) step(1'b0, 1'b0);
        n_tx = 0;
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0);
        check("drop_busy_clks", n_busy, TL);
        check("drop_no_tx_after", n_tx, 0);
        check("drop_count", {16'd0, burst_count}, 32'd6);

        // Enable rising during a single-shot gap chains the next burst directly.
        n_busy = 0;
        step(1'b0, 1'b1);
        for (int c = 0; c < 29; c++) step(1'b0, 1'b0);
        for (int c = 0; c < 12; c++) step(1'b1, 1'b0);
        check("chain_tx_high", {31'd0, tx_ir}, 32'd1);
        for (int c = 0; c < 60; c++) step(1'b0, 1'b0);
        check("chain_busy_clks", n_busy, 2 * TL);
        check("chain_count", {16'd0, burst_count}, 32'd8);

        // Asynchronous reset while the LED is lit.
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
        check("pre_reset_tx", {31'd0, tx_ir}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_out", {12'd0, tx_ir, burst_active, busy, sample_strobe, burst_count}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0);
        check("restart_high", {30'd0, tx_ir, burst_active}, 32'd3);
        for (int c = 0; c < 50; c++) step(1'b0, 1'b0);

        // Counter wrap from 0xFFFF.
        n_strobe = 0;
        step(1'b0, 1'b1);
        force dut.burst_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        step(1'b0, 1'b0);
        release dut.burst_count_q;
        for (int c = 0; c < 45; c++) step(1'b0, 1'b0);
        check("wrap_count", {16'd0, burst_count}, 32'd0);
        check("wrap_strobes", n_strobe, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
